demux_serializer_param: RTL and testbench



---
 rtl/serdes_pkg.sv | 18 +
 rtl/serdes_beat_counter.sv | 31 +++
 rtl/demux_serializer_param.sv | 109 ++++++++++
 tb/tb_demux_serializer_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and elaboration-time helpers for the wide-to-narrow serializer.
package serdes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int ratio(input int wide, input int narrow);
        return wide / narrow;
    endfunction

    // A single-beat word still needs a one-bit counter to keep the port legal.
    function automatic int beat_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/serdes_beat_counter.sv
// Beat index within the current word: cleared on a word load, advanced on each non-final beat transfer.
module serdes_beat_counter
    import serdes_pkg::*;
#(
    parameter int RATIO = 4
) (
    input  logic                        clk_f,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        inc,
    output logic [beat_w(RATIO)-1:0]    beat,
    output logic                        is_last
);

    localparam int BW = beat_w(RATIO);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    assign is_last = (beat == LAST_BEAT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            beat <= '0;
        end else if (clear) begin
            beat <= '0;
        end else if (inc && !is_last) begin
            beat <= beat + 1'b1;
        end
    end

endmodule

// File: rtl/demux_serializer_param.sv
// Splits each WIDE_W word into WIDE_W/NARROW_W beats with valid/ready on both sides.
// Define LSB_FIRST_EN to emit the least-significant slice first; default is MSB slice first.
module demux_serializer_param
    import serdes_pkg::*;
#(
    parameter int WIDE_W   = 32,
    parameter int NARROW_W = 8
) (
    input  logic                clk_f,
    input  logic                reset,
    input  logic [WIDE_W-1:0]   data_in,
    input  logic                valid_in,
    output logic                ready_in,
    output logic [NARROW_W-1:0] data_out,
    output logic                valid_out,
    output logic                last_out,
    input  logic                ready_out
);

    localparam int RATIO = ratio(WIDE_W, NARROW_W);
    localparam int BW    = beat_w(RATIO);

    generate
        if ((WIDE_W % NARROW_W) != 0 || RATIO < 2) begin : g_bad_widths
            $error("demux_serializer_param: WIDE_W must be a multiple of NARROW_W with ratio >= 2");
        end
    endgenerate

    state_t              state;
    state_t              state_d;
    logic [WIDE_W-1:0]   hold;
    logic [BW-1:0]       beat;
    logic                is_last;
    logic                load;
    logic                advance;
    logic                ready_int;

    serdes_beat_counter #(
        .RATIO (RATIO)
    ) u_beat_counter (
        .clk_f   (clk_f),
        .reset   (reset),
        .clear   (load),
        .inc     (advance),
        .beat    (beat),
        .is_last (is_last)
    );

    // NOTE: every combinational output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state;
        load      = 1'b0;
        advance   = 1'b0;
        valid_out = 1'b0;
        last_out  = 1'b0;
        ready_int = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (valid_in) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                valid_out = 1'b1;
                last_out  = is_last;
                ready_int = is_last & ready_out;
                if (ready_out) begin
                    if (!is_last) begin
                        advance = 1'b1;
                    end else if (valid_in) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_in = ready_int & ~reset;

    always_comb begin
        data_out = '0;
        if (state == SEND) begin
`ifdef LSB_FIRST_EN
            data_out = hold[int'(beat)*NARROW_W +: NARROW_W];
`else
            data_out = hold[WIDE_W-1-int'(beat)*NARROW_W -: NARROW_W];
`endif
        end
    end

    // NOTE: the hold register is reset too, so a discarded partial word never leaks after release.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                hold <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_demux_serializer_param.sv
// Scoreboard bench: accepted words are expanded into expected beats; a monitor pops them as the DUT emits.
module tb_demux_serializer_param;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clk_f = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        last_out;
    logic        ready_out = 1'b1;

    logic [63:0] d2_in = '0;
    logic        d2_valid_in = 1'b0;
    logic        d2_ready_in;
    logic [15:0] d2_out;
    logic        d2_valid_out;
    logic        d2_last_out;
    logic        d2_ready_out = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    beat_t q[$];

    always #5 clk_f = ~clk_f;

    demux_serializer_param dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .ready_out (ready_out)
    );

    demux_serializer_param #(
        .WIDE_W   (64),
        .NARROW_W (16)
    ) dut64 (
        .clk_f     (clk_f),
        .reset     (reset),
        .data_in   (d2_in),
        .valid_in  (d2_valid_in),
        .ready_in  (d2_ready_in),
        .data_out  (d2_out),
        .valid_out (d2_valid_out),
        .last_out  (d2_last_out),
        .ready_out (d2_ready_out)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference slicing: beat k of a word, by shift and mask.
    function automatic logic [63:0] slice_of(input logic [63:0] w, input int wide, input int narrow, input int k);
        int sh;
`ifdef LSB_FIRST_EN
        sh = k * narrow;
`else
        sh = wide - narrow * (k + 1);
`endif
        return (w >> sh) & ((64'd1 << narrow) - 64'd1);
    endfunction

    // Monitor / scoreboard for the 32->8 instance.
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    always @(negedge clk_f) begin
        if (reset) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            check("valid_out", {63'd0, valid_out}, {63'd0, q.size() != 0});
            check("ready_in", {63'd0, ready_in},
                  {63'd0, (q.size() == 0) || (q.size() == 1 && ready_out)});
            if (stall_prev) begin
                check("stall_data", {56'd0, data_out}, {56'd0, prev_data});
                check("stall_last", {63'd0, last_out}, {63'd0, prev_last});
            end
            if (!valid_out) begin
                check("idle_data", {56'd0, data_out}, 64'd0);
                check("idle_last", {63'd0, last_out}, 64'd0);
            end else if (q.size() != 0) begin
                check("beat_data", {56'd0, data_out}, {56'd0, q[0].data});
                check("beat_last", {63'd0, last_out}, {63'd0, q[0].last});
                if (ready_out) void'(q.pop_front());
            end
            stall_prev = valid_out && !ready_out;
            prev_data  = data_out;
            prev_last  = last_out;
            if (valid_in && ready_in) begin
                for (int k = 0; k < 4; k++) begin
                    beat_t b;
                    b.data = slice_of({32'd0, data_in}, 32, 8, k)[7:0];
                    b.last = (k == 3);
                    q.push_back(b);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        bit acc;
        acc = 1'b0;
        data_in  = w;
        valid_in = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_f);
            acc = ready_in;
            @(posedge clk_f);
            #1;
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_f);
        #1;
    endtask

    initial begin
        #(400000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [63:0] w64;

        // Reset state
        #3;
        check("rst_ready_in", {63'd0, ready_in}, 64'd0);
        check("rst_valid_out", {63'd0, valid_out}, 64'd0);
        check("rst_last_out", {63'd0, last_out}, 64'd0);
        check("rst_data_out", {56'd0, data_out}, 64'd0);
        repeat (3) @(posedge clk_f);
        #2 reset = 1'b0;
        #1 check("post_rst_ready_in", {63'd0, ready_in}, 64'd1);
        wait_cycles(2);

        // Single word with ready held high
        send_word(32'hAABBCCDD);
        valid_in = 1'b0;
        wait_cycles(6);

        // Back-to-back words, valid held high
        send_word(32'h11223344);
        send_word(32'h55667788);
        valid_in = 1'b0;
        wait_cycles(8);

        // Stall on the second beat
        send_word(32'hAABBCCDD);
        valid_in = 1'b0;
        wait_cycles(1);
        ready_out = 1'b0;
        wait_cycles(3);
        ready_out = 1'b1;
        wait_cycles(6);

        // Reset while the third beat is presented
        send_word(32'hAABBCCDD);
        valid_in = 1'b0;
        wait_cycles(1);
        @(posedge clk_f);
        #3 reset = 1'b1;
        #1;
        check("midrst_valid_out", {63'd0, valid_out}, 64'd0);
        check("midrst_ready_in", {63'd0, ready_in}, 64'd0);
        check("midrst_data_out", {56'd0, data_out}, 64'd0);
        @(posedge clk_f);
        #2 reset = 1'b0;
        #1 check("midrst_release_ready", {63'd0, ready_in}, 64'd1);
        wait_cycles(6);

        // Randomized traffic with random back-pressure
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_f);
            acc = valid_in && ready_in;
            @(posedge clk_f);
            #1;
            ready_out = ($urandom_range(0, 3) != 0);
            if (acc || !valid_in) begin
                valid_in = ($urandom_range(0, 2) != 0);
                data_in  = $urandom();
            end
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        wait_cycles(10);
        check("drain_empty", 64'(q.size()), 64'd0);

        // 64->16 instance
        w64 = 64'h0123456789ABCDEF;
        d2_in = w64;
        d2_valid_in = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            @(negedge clk_f);
            acc = d2_ready_in;
            @(posedge clk_f);
            #1;
        end
        if (!acc) check("w64_accept_timeout", 64'd0, 64'd1);
        d2_valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_f);
            check("w64_valid", {63'd0, d2_valid_out}, 64'd1);
            check("w64_data", {48'd0, d2_out}, slice_of(w64, 64, 16, k));
            check("w64_last", {63'd0, d2_last_out}, {63'd0, k == 3});
        end
        @(negedge clk_f);
        check("w64_done", {63'd0, d2_valid_out}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
